// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM subsystem.
// FSM state encoding, RAM opcode values and default word widths.
package spi_ram_pkg;

   localparam int FRAME_W_DEF = 10;
   localparam int DATA_W_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with a down-counting bits-remaining counter; one bit per enabled edge.
// Shifting stops when the counter reaches zero; clear beats load, load beats arm, arm beats shift.
module spi_shift_reg #(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             arm_i,
   input  logic             load_i,
   input  logic [W-1:0]     load_dat_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [W-1:0]     par_o,
   output logic             ser_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

   logic [W-1:0]     sr_q;
   logic [CNT_W-1:0] cnt_q;

   // arm restarts the count without disturbing the held data word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         sr_q  <= load_dat_i;
         cnt_q <= CNT_FULL;
      end else if (arm_i) begin
         cnt_q <= CNT_FULL;
      end else if (shift_i && (cnt_q != '0)) begin
         sr_q  <= {sr_q[W-2:0], ser_i};
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign par_o = sr_q;
   assign ser_o = sr_q[W-1];
   assign cnt_o = cnt_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: MOSI frames -> FRAME_W command words with a one-cycle rx_valid; RAM read data -> MISO.
// SS_n high aborts anything in flight. Define SPI_OPCODE_CHECK_EN to add opcode_err and opcode checking.
module spi_slave
   import spi_ram_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
`ifdef SPI_OPCODE_CHECK_EN
   ,
   output logic               opcode_err
`endif
);

   localparam int RX_CNT_W = $clog2(FRAME_W + 1);
   localparam int TX_CNT_W = $clog2(DATA_W + 1);

   state_t              state_q;
   logic                rd_addr_seen_q;
   logic                done_q;
   logic                rx_valid_q;
   logic                wait_tx_q;
   logic                miso_q;

   logic [FRAME_W-1:0]  rx_par;
   logic                rx_ser;
   logic [RX_CNT_W-1:0] rx_cnt;
   logic [DATA_W-1:0]   tx_par;
   logic                tx_msb;
   logic [TX_CNT_W-1:0] tx_cnt;

   logic rx_arm, rx_shift, last_bit, op_ok;
   logic tx_load, tx_shift;

   always_comb begin
      rx_arm   = (state_q == CHK_CMD) && !SS_n;
      rx_shift = ((state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA)) && !SS_n;
      last_bit = rx_shift && (rx_cnt == RX_CNT_W'(1));
      tx_shift = (state_q == READ_DATA) && !SS_n;
      tx_load  = tx_shift && wait_tx_q && tx_valid;
   end

`ifdef SPI_OPCODE_CHECK_EN
   logic [1:0] opcode;
   logic       err_q;
   logic       opcode_err_q;

   // opcode sits one position below the top until the final bit shifts in
   assign opcode = rx_par[FRAME_W-2 -: 2];

   always_comb begin
      op_ok = 1'b1;
      case (state_q)
         WRITE:     op_ok = (opcode == OP_WR_ADDR) || (opcode == OP_WR_DATA);
         READ_ADD:  op_ok = (opcode == OP_RD_ADDR);
         READ_DATA: op_ok = (opcode == OP_RD_DATA);
         default:   op_ok = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q        <= 1'b0;
         opcode_err_q <= 1'b0;
      end else begin
         err_q        <= last_bit && !op_ok;
         opcode_err_q <= err_q;
      end
   end

   assign opcode_err = opcode_err_q;
`else
   assign op_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         rd_addr_seen_q <= 1'b0;
         done_q         <= 1'b0;
         rx_valid_q     <= 1'b0;
         wait_tx_q      <= 1'b0;
         miso_q         <= 1'b0;
      end else begin
         done_q     <= last_bit && op_ok;
         rx_valid_q <= done_q;
         miso_q     <= (tx_shift && (tx_cnt != '0)) ? tx_msb : 1'b0;

         if (SS_n) begin
            state_q   <= IDLE;
            wait_tx_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE:    state_q <= CHK_CMD;
               CHK_CMD: state_q <= !MOSI ? WRITE : (rd_addr_seen_q ? READ_DATA : READ_ADD);
               default: state_q <= state_q;
            endcase
            // response window opens together with the rx_valid strobe
            if (done_q && (state_q == READ_DATA))
               wait_tx_q <= 1'b1;
            else if (tx_load)
               wait_tx_q <= 1'b0;
         end

         if (last_bit && op_ok) begin
            if (state_q == READ_ADD)
               rd_addr_seen_q <= 1'b1;
            else if (state_q == READ_DATA)
               rd_addr_seen_q <= 1'b0;
         end
      end
   end

   spi_shift_reg #(.W(FRAME_W), .CNT_W(RX_CNT_W)) u_rx_sr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (SS_n),
      .arm_i      (rx_arm),
      .load_i     (1'b0),
      .load_dat_i ('0),
      .shift_i    (rx_shift),
      .ser_i      (MOSI),
      .par_o      (rx_par),
      .ser_o      (rx_ser),
      .cnt_o      (rx_cnt)
   );

   spi_shift_reg #(.W(DATA_W), .CNT_W(TX_CNT_W)) u_tx_sr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (SS_n),
      .arm_i      (1'b0),
      .load_i     (tx_load),
      .load_dat_i (tx_data),
      .shift_i    (tx_shift),
      .ser_i      (1'b0),
      .par_o      (tx_par),
      .ser_o      (tx_msb),
      .cnt_o      (tx_cnt)
   );

   logic unused_bits;
   assign unused_bits = ^{rx_ser, tx_par};

   assign MISO     = miso_q;
   assign rx_data  = rx_par;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frame table plus reset, abort, read shift-out and opcode sequences.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_spi_slave;
   import spi_ram_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
`ifdef SPI_OPCODE_CHECK_EN
   logic       opcode_err;
`endif

   int total  = 0;
   int passed = 0;

   spi_slave dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_OPCODE_CHECK_EN
      ,
      .opcode_err (opcode_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish before 200us");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic       cmd;
      logic [9:0] bits;
      logic [9:0] exp_dat;
      logic       exp_seen;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   // starts from IDLE with SS_n high; leaves SS_n low after the last bit edge
   task automatic frame(input logic cmd, input logic [9:0] bits, input int nbits);
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick();
      MOSI = cmd;
      tick();
      for (int i = 9; i > 9 - nbits; i--) begin
         MOSI = bits[i];
         tick();
      end
   endtask

   task automatic end_frame();
      SS_n = 1'b1;
      MOSI = 1'b0;
      tick();
   endtask

   vec_t       vecs [6];
   logic [7:0] rd_byte;

   initial begin
      vecs[0] = '{1'b0, 10'h03C, 10'h03C, 1'b0};
      vecs[1] = '{1'b0, 10'h1A5, 10'h1A5, 1'b0};
      vecs[2] = '{1'b1, 10'h23C, 10'h23C, 1'b1};
      vecs[3] = '{1'b0, 10'h0FF, 10'h0FF, 1'b1};
      vecs[4] = '{1'b1, 10'h300, 10'h300, 1'b0};
      vecs[5] = '{1'b1, 10'h2C3, 10'h2C3, 1'b1};

      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tick();
      check("reset rx_data", rx_data, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset MISO", MISO, 0);
      check("reset state", dut.state_q, IDLE);
      check("reset rd_addr_seen", dut.rd_addr_seen_q, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         frame(vecs[v].cmd, vecs[v].bits, 10);
         check($sformatf("vec%0d no strobe on last bit", v), rx_valid, 0);
         end_frame();
         check($sformatf("vec%0d rx_valid", v), rx_valid, 1);
         check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_dat);
         check($sformatf("vec%0d MISO", v), MISO, 0);
`ifdef SPI_OPCODE_CHECK_EN
         check($sformatf("vec%0d opcode_err", v), opcode_err, 0);
`endif
         tick();
         check($sformatf("vec%0d strobe one cycle", v), rx_valid, 0);
         check($sformatf("vec%0d rd_addr_seen", v), dut.rd_addr_seen_q, vecs[v].exp_seen);
      end

      // asynchronous reset in the middle of a frame
      frame(1'b0, 10'h155, 5);
      rst_n = 1'b0;
      #1;
      check("midreset rx_data", rx_data, 0);
      check("midreset rx_valid", rx_valid, 0);
      check("midreset MISO", MISO, 0);
      check("midreset state", dut.state_q, IDLE);
      check("midreset rd_addr_seen", dut.rd_addr_seen_q, 0);
      SS_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      frame(1'b0, 10'h155, 10);
      end_frame();
      check("post-reset rx_valid", rx_valid, 1);
      check("post-reset rx_data", rx_data, 10'h155);
      tick();

      // write frame aborted after 6 bits, then a full frame with trailing extra bits
      frame(1'b0, 10'h1A5, 6);
      end_frame();
      check("abort no rx_valid", rx_valid, 0);
      tick();
      check("abort no rx_valid later", rx_valid, 0);
      check("abort state", dut.state_q, IDLE);
      frame(1'b0, 10'h03C, 10);
      MOSI = 1'b1;
      tick();
      check("after-abort rx_valid", rx_valid, 1);
      check("after-abort rx_data", rx_data, 10'h03C);
      tick();
      tick();
      check("extra bits rx_data", rx_data, 10'h03C);
      check("extra bits rx_valid", rx_valid, 0);
      end_frame();
      tick();

      // read address then read data with response three cycles after rx_valid
      frame(1'b1, 10'h23C, 10);
      end_frame();
      check("rd-addr rx_data", rx_data, 10'h23C);
      tick();
      check("rd-addr seen", dut.rd_addr_seen_q, 1);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      frame(1'b1, 10'h300, 10);
      tx_valid = 1'b0;
      MOSI     = 1'b0;
      tick();
      check("rd-data rx_valid", rx_valid, 1);
      check("rd-data rx_data", rx_data, 10'h300);
      check("early tx_valid ignored", MISO, 0);
      tick();
      tick();
      check("MISO idle while waiting", MISO, 0);
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      tick();
      check("MISO idle at capture edge", MISO, 0);
      rd_byte = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         tx_valid = (k == 2);
         tx_data  = 8'h00;
         tick();
         check($sformatf("MISO bit %0d", 7 - k), MISO, rd_byte[7-k]);
      end
      tx_valid = 1'b0;
      tick();
      check("MISO after bit 0", MISO, 0);
      check("rd-data seen cleared", dut.rd_addr_seen_q, 0);
      end_frame();
      tick();

      // read shift-out aborted by SS_n after four bits
      frame(1'b1, 10'h2AA, 10);
      end_frame();
      tick();
      frame(1'b1, 10'h3FF, 10);
      tick();
      check("abort-rd rx_valid", rx_valid, 1);
      tx_valid = 1'b1;
      tx_data  = 8'hF0;
      tick();
      tx_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("abort-rd MISO bit %0d", 7 - k), MISO, 1);
      end
      end_frame();
      check("abort-rd MISO dropped", MISO, 0);
      check("abort-rd state", dut.state_q, IDLE);
      tick();
      check("abort-rd MISO stays 0", MISO, 0);

`ifdef SPI_OPCODE_CHECK_EN
      // READ_ADD frame carrying a write-data opcode
      frame(1'b1, 10'h15A, 10);
      end_frame();
      check("operr rx_valid suppressed", rx_valid, 0);
      check("operr pulse", opcode_err, 1);
      tick();
      check("operr one cycle", opcode_err, 0);
      check("operr seen unchanged", dut.rd_addr_seen_q, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
